mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ERR_ON_MISALIGN, default 1, meaning: 1 = misaligned request is rejected with error; 0 = offending low address bits forced to zero, access proceeds.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer takes response.
REQ-014 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-015 resp_err  output  1  request rejected (misaligned or illegal size).
REQ-016 mem_we  output  1  data-memory write enable.
REQ-017 mem_addr  output  32  word-aligned address to data memory ([1:0] always 00).
REQ-018 mem_wr_data  output  32  full word to write.
REQ-019 mem_rd_data  input  32  data-memory combinational read data for mem_addr.

Function
REQ-020 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with rst low; handshake = req_valid & req_ready at a rising edge.
REQ-022 On accept, the block SHALL latch req_we, req_size, req_unsigned, req_addr, req_wdata; mem_addr = {addr[31:2],2'b00} from the next cycle.
REQ-023 Misalignment: half with addr[0]=1, word with addr[1:0]!=00; size 11 always an error regardless of ERR_ON_MISALIGN.
REQ-024 Error path (ERR_ON_MISALIGN=1 or size 11): IDLE -> RESP, resp_err=1, resp_rdata=0, no memory write.
REQ-025 Load: IDLE -> READ -> RESP; in READ the block SHALL capture mem_rd_data; resp_valid first asserted 2 cycles after accept.
REQ-026 Load extraction little-endian: byte lane n = bits [8n+7:8n] selected by addr[1:0]; half lane by addr[1]; extension per req_unsigned; word returned unchanged.
REQ-027 Store word: IDLE -> WRITE -> RESP; mem_we=1 for exactly the WRITE cycle with mem_wr_data = wdata.
REQ-028 Store byte/half: IDLE -> READ -> WRITE -> RESP; old word captured in READ, only the addressed lane(s) replaced in WRITE; resp_valid 3 cycles after accept.
REQ-029 mem_we SHALL be 1 only in WRITE and SHALL be forced 0 whenever rst is high.
REQ-030 RESP SHALL hold resp_valid, resp_rdata, resp_err stable until resp_valid & resp_ready, then return to IDLE; no new request accepted in that same cycle.
REQ-031 Outside RESP, resp_valid=0; outside WRITE, mem_wr_data SHALL be 0.

Reset
REQ-032 rst high at a rising edge SHALL force IDLE from any state, abandoning any in-flight access without a memory write.
REQ-033 Post-reset values: req_ready=1 (once rst low), resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wr_data=0, all latches 0.

Verification
REQ-034 Memory word 0x8 = 0x11223384; LB addr 0x8 signed -> resp_rdata 0xFFFFFF84, resp_valid 2 cycles after accept, resp_err 0.
REQ-035 Same word; LHU addr 0xA -> 0x00001122; LH addr 0x8 -> 0x00003384.
REQ-036 SB addr 0x9 data 0xAB onto 0x11223384 -> single mem_we pulse, mem_addr 0x8, mem_wr_data 0x1122AB84, resp 3 cycles after accept.
REQ-037 LW addr 0x6 (ERR_ON_MISALIGN=1) -> resp_err 1, resp_rdata 0, mem_we never asserted; with ERR_ON_MISALIGN=0 -> returns word at 0x4.
REQ-038 SH addr 0x4 with rst asserted during READ -> no mem_we pulse, FSM IDLE next cycle, memory unchanged.
REQ-039 resp_ready held low 5 cycles after LW response -> resp_valid and resp_rdata stable throughout, req_ready 0 until the cycle after the handshake.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Turns byte/halfword/word load and store requests into single-word accesses
// on a word-wide data memory with a combinational read port. Sub-word stores
// are done as read-modify-write. Loads are lane-extracted (little-endian) and
// sign- or zero-extended.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid & ready are both 1. The request side is ready only in IDLE with rst
// low. The response side holds resp_valid/resp_rdata/resp_err stable until
// resp_ready is seen; no new request is taken in that same cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      load extension: 1 = zero, 0 = sign
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          request rejected (misaligned or illegal size)
//   mem_we            memory write enable (WRITE state only)
//   mem_addr          word-aligned memory address
//   mem_wr_data       full word written (0 outside WRITE)
//   mem_rd_data       combinational memory read data for mem_addr
//   dbg_state         current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    // 1: misaligned requests are rejected with resp_err.
    // 0: misaligned low address bits are forced to zero and the access proceeds.
    parameter int unsigned ERR_ON_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam bit REJECT_MISALIGN = (ERR_ON_MISALIGN != 0);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Request decode
    logic        req_illegal;
    logic        req_misal;
    logic        req_reject;
    logic [31:0] req_addr_eff;

    always_comb begin
        req_illegal  = (req_size == 2'b11);
        req_misal    = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        req_reject   = req_illegal || (req_misal && REJECT_MISALIGN);
        // Clearing the sub-size bits is a no-op for aligned requests and
        // implements the "force to zero" behaviour when misalignment is allowed.
        req_addr_eff = req_addr;
        if (req_size == 2'b01) begin
            req_addr_eff[0] = 1'b0;
        end else if (req_size == 2'b10) begin
            req_addr_eff[1:0] = 2'b00;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores,
    // both working on the word currently presented by the memory.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        rd_byte = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = mem_rd_data;
        endcase
        merged = mem_rd_data;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr_eff;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (req_reject) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        // Full-word store needs no read of the old word.
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    merge_d = merged;
                    state_d = WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == IDLE) && !rst;
    assign resp_valid  = (state_q == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    // Gated by rst so an abandoned access can never write on the reset edge.
    assign mem_we      = (state_q == WRITE) && !rst;
    assign mem_addr    = {addr_q[31:2], 2'b00};
    assign mem_wr_data = (state_q != WRITE) ? 32'h0 :
                         (size_q == 2'b10)  ? wdata_q : merge_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two instances: dut_a rejects misaligned requests, dut_b aligns them down.
// Each instance has its own word memory in the bench plus a shadow copy
// (ref_mem) that the byte-level reference model reads and updates.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        req_ready_a, resp_valid_a, resp_err_a, mem_we_a;
    logic [31:0] resp_rdata_a, mem_addr_a, mem_wr_data_a, mem_rd_data_a;
    logic [1:0]  dbg_state_a;
    logic        req_ready_b, resp_valid_b, resp_err_b, mem_we_b;
    logic [31:0] resp_rdata_b, mem_addr_b, mem_wr_data_b, mem_rd_data_b;
    logic [1:0]  dbg_state_b;

    mem_access_unit #(.ERR_ON_MISALIGN(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wr_data(mem_wr_data_a),
        .mem_rd_data(mem_rd_data_a), .dbg_state(dbg_state_a)
    );

    mem_access_unit #(.ERR_ON_MISALIGN(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b),
        .mem_rd_data(mem_rd_data_b), .dbg_state(dbg_state_b)
    );

    // ---------------- memories ----------------
    logic [31:0] mem     [2][64];
    logic [31:0] ref_mem [2][64];
    int          we_cnt  [2];
    logic [31:0] last_waddr [2];
    logic [31:0] last_wdata [2];
    logic        bd_we;
    logic        bd_sel;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    assign mem_rd_data_a = mem[0][mem_addr_a[7:2]];
    assign mem_rd_data_b = mem[1][mem_addr_b[7:2]];

    always @(posedge clk) begin
        if (bd_we) mem[bd_sel][bd_idx] <= bd_data;
        if (mem_we_a) begin
            mem[0][mem_addr_a[7:2]] <= mem_wr_data_a;
            we_cnt[0]     <= we_cnt[0] + 1;
            last_waddr[0] <= mem_addr_a;
            last_wdata[0] <= mem_wr_data_a;
        end
        if (mem_we_b) begin
            mem[1][mem_addr_b[7:2]] <= mem_wr_data_b;
            we_cnt[1]     <= we_cnt[1] + 1;
            last_waddr[1] <= mem_addr_b;
            last_wdata[1] <= mem_wr_data_b;
        end
    end

    int total = 0;
    int bad   = 0;

    // ---------------- output selectors ----------------
    function automatic logic get_ready(input int s);
        return (s == 0) ? req_ready_a : req_ready_b;
    endfunction
    function automatic logic get_rvalid(input int s);
        return (s == 0) ? resp_valid_a : resp_valid_b;
    endfunction
    function automatic logic [31:0] get_rdata(input int s);
        return (s == 0) ? resp_rdata_a : resp_rdata_b;
    endfunction
    function automatic logic get_err(input int s);
        return (s == 0) ? resp_err_a : resp_err_b;
    endfunction

    // ---------------- reference model ----------------
    // Instance 0 rejects misalignment, instance 1 does not.
    function automatic bit model_err(input int s, input logic [1:0] size, input logic [31:0] addr);
        int n;
        bit misal;
        n = 1 << size;
        misal = (size != 2'd3) && ((addr % 4) % n != 0);
        return (size == 2'd3) || (misal && s == 0);
    endfunction

    // Effective byte offset inside the word: rounded down to the access size.
    function automatic int model_off(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = 1 << size;
        return ((addr % 4) / n) * n;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr);
        int n, off;
        longint v;
        n = 1 << size;
        off = model_off(size, addr);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'((word >> (8 * (off + i))) & 32'hFF) << (8 * i);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [31:0] wdata, input logic [31:0] addr);
        logic [7:0] b [4];
        int n, off;
        n = 1 << size;
        off = model_off(size, addr);
        for (int k = 0; k < 4; k++) b[k] = 8'((word >> (8 * k)) & 32'hFF);
        for (int i = 0; i < n; i++) b[off + i] = 8'((wdata >> (8 * i)) & 32'hFF);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic int model_lat(input bit err, input logic we, input logic [1:0] size);
        if (err) return 1;
        if (we && size != 2'd2) return 3;
        return 2;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bd_write(input int s, input int idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_sel = s[0]; bd_idx = idx[5:0]; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[s][idx] = d;
    endtask

    // Issues one request and waits (bounded) for resp_valid; returns the
    // number of cycles from the accept edge to the first resp_valid cycle.
    task automatic send_req(input int s, input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output bit timeout);
        int guard = 0;
        timeout = 1'b0;
        while (get_ready(s) !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout = 1'b1;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (s == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 1;
        while (get_rvalid(s) !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 10) timeout = 1'b1;
    endtask

    task automatic finish_resp(input int delay);
        repeat (delay) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (req_ready_a !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: got %b exp 0", req_ready_a); end
        total++; if (mem_we_a !== 1'b0) begin bad++; $display("FAIL reset_we_in_rst: got %b exp 0", mem_we_a); end
        rst = 1'b0;
        #1;
        total++; if (req_ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", req_ready_a); end
        total++; if (req_ready_b !== 1'b1) begin bad++; $display("FAIL reset_ready_b: got %b exp 1", req_ready_b); end
        total++; if (resp_valid_a !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid_a); end
        total++; if (resp_rdata_a !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", resp_rdata_a); end
        total++; if (resp_err_a !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", resp_err_a); end
        total++; if (mem_addr_a !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr_a); end
        total++; if (mem_wr_data_a !== 32'h0) begin bad++; $display("FAIL reset_wr_data: got %h exp 0", mem_wr_data_a); end
        total++; if (dbg_state_a !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d exp 0", dbg_state_a); end
    endtask

    task automatic fill_memories();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) bd_write(s, i, $urandom);
        bd_write(0, 2, 32'h11223384);
        bd_write(1, 2, 32'h11223384);
    endtask

    task automatic test_directed();
        logic        t_we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  t_size [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        logic        t_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_addr [4] = '{32'h8, 32'hA, 32'h8, 32'h9};
        logic [31:0] t_wd   [4] = '{32'h0, 32'h0, 32'h0, 32'hAB};
        logic [31:0] t_rd   [4] = '{32'hFFFFFF84, 32'h00001122, 32'h00003384, 32'h0};
        int          t_lat  [4] = '{2, 2, 2, 3};
        int          t_puls [4] = '{0, 0, 0, 1};
        int lat, w0;
        bit to;
        for (int i = 0; i < 4; i++) begin
            w0 = we_cnt[0];
            send_req(0, t_we[i], t_size[i], t_uns[i], t_addr[i], t_wd[i], lat, to);
            total++; if (to) begin bad++; $display("FAIL dir_timeout[%0d]: got timeout exp response", i); end
            total++; if (resp_rdata_a !== t_rd[i]) begin bad++; $display("FAIL dir_rdata[%0d]: got %h exp %h", i, resp_rdata_a, t_rd[i]); end
            total++; if (resp_err_a !== 1'b0) begin bad++; $display("FAIL dir_err[%0d]: got %b exp 0", i, resp_err_a); end
            total++; if (lat != t_lat[i]) begin bad++; $display("FAIL dir_latency[%0d]: got %0d exp %0d", i, lat, t_lat[i]); end
            finish_resp(0);
            total++; if (we_cnt[0] - w0 != t_puls[i]) begin bad++; $display("FAIL dir_we_pulses[%0d]: got %0d exp %0d", i, we_cnt[0] - w0, t_puls[i]); end
        end
        total++; if (last_waddr[0] !== 32'h8) begin bad++; $display("FAIL dir_sb_addr: got %h exp 00000008", last_waddr[0]); end
        total++; if (last_wdata[0] !== 32'h1122AB84) begin bad++; $display("FAIL dir_sb_wdata: got %h exp 1122ab84", last_wdata[0]); end
        total++; if (mem[0][2] !== 32'h1122AB84) begin bad++; $display("FAIL dir_sb_mem: got %h exp 1122ab84", mem[0][2]); end
        ref_mem[0][2] = 32'h1122AB84;
    endtask

    task automatic test_misalign();
        int          t_s    [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        logic        t_we   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  t_size [8] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd3};
        logic        t_uns  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_addr [8] = '{32'h6, 32'h6, 32'hB, 32'h10, 32'h6, 32'hB, 32'h15, 32'h20};
        logic [31:0] t_wd   [8] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1234BEEF, 32'h55};
        int s, idx, lat, w0, e_lat, e_puls;
        bit to, e_err;
        logic [31:0] e_rd;
        for (int i = 0; i < 8; i++) begin
            s = t_s[i];
            idx = int'(t_addr[i][7:2]);
            e_err = model_err(s, t_size[i], t_addr[i]);
            e_rd = (e_err || t_we[i]) ? 32'h0 : model_load(ref_mem[s][idx], t_size[i], t_uns[i], t_addr[i]);
            e_lat = model_lat(e_err, t_we[i], t_size[i]);
            e_puls = (!e_err && t_we[i]) ? 1 : 0;
            w0 = we_cnt[s];
            send_req(s, t_we[i], t_size[i], t_uns[i], t_addr[i], t_wd[i], lat, to);
            total++; if (to) begin bad++; $display("FAIL mis_timeout[%0d]: got timeout exp response", i); end
            total++; if (get_err(s) !== e_err) begin bad++; $display("FAIL mis_err[%0d]: got %b exp %b", i, get_err(s), e_err); end
            total++; if (get_rdata(s) !== e_rd) begin bad++; $display("FAIL mis_rdata[%0d]: got %h exp %h", i, get_rdata(s), e_rd); end
            total++; if (lat != e_lat) begin bad++; $display("FAIL mis_latency[%0d]: got %0d exp %0d", i, lat, e_lat); end
            finish_resp(1);
            total++; if (we_cnt[s] - w0 != e_puls) begin bad++; $display("FAIL mis_we_pulses[%0d]: got %0d exp %0d", i, we_cnt[s] - w0, e_puls); end
            if (e_puls == 1) ref_mem[s][idx] = model_store(ref_mem[s][idx], t_size[i], t_wd[i], t_addr[i]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e_rd;
        int lat;
        bit to;
        e_rd = ref_mem[0][4];
        send_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout: got timeout exp response"); end
        for (int c = 0; c < 5; c++) begin
            total++; if (resp_valid_a !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b exp 1", c, resp_valid_a); end
            total++; if (resp_rdata_a !== e_rd) begin bad++; $display("FAIL bp_rdata[%0d]: got %h exp %h", c, resp_rdata_a, e_rd); end
            total++; if (req_ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %b exp 0", c, req_ready_a); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        total++; if (req_ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready_hs: got %b exp 0", req_ready_a); end
        @(negedge clk);
        resp_ready = 1'b0;
        total++; if (req_ready_a !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b exp 1", req_ready_a); end
        total++; if (resp_valid_a !== 1'b0) begin bad++; $display("FAIL bp_valid_after: got %b exp 0", resp_valid_a); end
    endtask

    // Reset while a sub-word store is in flight; stop_state 1 = READ, 2 = WRITE.
    task automatic test_reset_abort(input logic [1:0] stop_state, input logic [1:0] size, input logic [31:0] addr);
        int w0, idx;
        idx = int'(addr[7:2]);
        w0 = we_cnt[0];
        req_we = 1'b1; req_size = size; req_unsigned = 1'b0; req_addr = addr; req_wdata = $urandom;
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        if (stop_state == 2'd2) @(negedge clk);
        total++; if (dbg_state_a !== stop_state) begin bad++; $display("FAIL abort_state_pre: got %0d exp %0d", dbg_state_a, stop_state); end
        rst = 1'b1;
        #1;
        total++; if (mem_we_a !== 1'b0) begin bad++; $display("FAIL abort_we_in_rst: got %b exp 0", mem_we_a); end
        total++; if (req_ready_a !== 1'b0) begin bad++; $display("FAIL abort_ready_in_rst: got %b exp 0", req_ready_a); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (dbg_state_a !== 2'd0) begin bad++; $display("FAIL abort_state_post: got %0d exp 0", dbg_state_a); end
        total++; if (resp_valid_a !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b exp 0", resp_valid_a); end
        repeat (2) @(negedge clk);
        total++; if (we_cnt[0] != w0) begin bad++; $display("FAIL abort_we_pulses: got %0d exp 0", we_cnt[0] - w0); end
        total++; if (mem[0][idx] !== ref_mem[0][idx]) begin bad++; $display("FAIL abort_mem: got %h exp %h", mem[0][idx], ref_mem[0][idx]); end
    endtask

    task automatic test_random();
        int s, idx, lat, w0, e_lat, e_puls, r;
        bit to, e_err;
        logic we, uns;
        logic [1:0] size;
        logic [31:0] addr, wd, e_rd;
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63);
            addr = 32'(idx * 4 + $urandom_range(0, 3));
            wd = $urandom;
            e_err = model_err(s, size, addr);
            e_rd = (e_err || we) ? 32'h0 : model_load(ref_mem[s][idx], size, uns, addr);
            e_lat = model_lat(e_err, we, size);
            e_puls = (!e_err && we) ? 1 : 0;
            w0 = we_cnt[s];
            send_req(s, we, size, uns, addr, wd, lat, to);
            total++; if (to) begin bad++; $display("FAIL rnd_timeout[%0d]: got timeout exp response", i); end
            total++; if (get_err(s) !== e_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b exp %b", i, get_err(s), e_err); end
            total++; if (get_rdata(s) !== e_rd) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", i, get_rdata(s), e_rd); end
            total++; if (lat != e_lat) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", i, lat, e_lat); end
            finish_resp($urandom_range(0, 3));
            total++; if (we_cnt[s] - w0 != e_puls) begin bad++; $display("FAIL rnd_we_pulses[%0d]: got %0d exp %0d", i, we_cnt[s] - w0, e_puls); end
            total++; if (get_ready(s) !== 1'b1) begin bad++; $display("FAIL rnd_ready_after[%0d]: got %b exp 1", i, get_ready(s)); end
            if (e_puls == 1) begin
                total++; if (last_waddr[s] !== 32'(idx * 4)) begin bad++; $display("FAIL rnd_waddr[%0d]: got %h exp %h", i, last_waddr[s], 32'(idx * 4)); end
                ref_mem[s][idx] = model_store(ref_mem[s][idx], size, wd, addr);
            end
        end
    endtask

    task automatic test_final_memory();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 64; i++) begin
                total++;
                if (mem[s][i] !== ref_mem[s][i]) begin
                    bad++;
                    $display("FAIL final_mem[%0d][%0d]: got %h exp %h", s, i, mem[s][i], ref_mem[s][i]);
                end
            end
    endtask

    initial begin
        rst = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        bd_we = 1'b0; bd_sel = 1'b0; bd_idx = 6'd0; bd_data = 32'h0;

        test_reset();
        fill_memories();
        test_directed();
        test_misalign();
        test_backpressure();
        test_reset_abort(2'd1, 2'd1, 32'h4);
        test_reset_abort(2'd2, 2'd0, 32'h21);
        test_random();
        test_final_memory();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
